// File: rtl/instr_fetch.sv
// Instruction fetch/issue unit: holds the PC, fetches one word at a time over a
// valid/ready imem port, latches it in IR and presents decode fields to the
// control decoder. Only one instruction is in flight and there is no prefetch.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_FETCH | request outstanding on imem, addr = pc, waiting for ready
// S_WAIT  | request accepted, waiting for the single response word
// S_ISSUE | IR valid, waiting for execute to report instr_done
// S_HALT  | misaligned target taken; fetch stopped until reset
module instr_fetch #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter logic [31:0]      NOP_WORD = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [31:0]     instr,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7,
    output logic [XLEN-1:0] pc,
    output logic            instr_valid,
    input  logic            instr_done,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic            halted
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc_q, pc_nxt;
    logic [31:0]     ir_q, ir_nxt;
    logic            halted_q, halted_nxt;
    logic            req_valid_q, req_valid_nxt;
    logic            instr_valid_q, instr_valid_nxt;
    logic [XLEN-1:0] next_pc;

    // Next-state, next-PC and IR update; registered outputs follow the next state.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc_q;
        ir_nxt     = ir_q;
        halted_nxt = halted_q;
        next_pc    = PCSrc ? PCTarget : (pc_q + XLEN'(4));

        case (state)
            S_FETCH: begin
                // req_valid_q is low for the first cycle out of reset, so a ready
                // seen then is not an acceptance.
                if (req_valid_q && imem_req_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    ir_nxt    = imem_rsp_data;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (instr_done) begin
                    if (next_pc[1:0] == 2'b00) begin
                        pc_nxt    = next_pc;
                        state_nxt = S_FETCH;
                    end else begin
                        ir_nxt     = NOP_WORD;
                        halted_nxt = 1'b1;
                        state_nxt  = S_HALT;
                    end
                end
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase

        req_valid_nxt   = (state_nxt == S_FETCH);
        instr_valid_nxt = (state_nxt == S_ISSUE);
    end

    // State and output registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_FETCH;
            pc_q          <= RESET_PC;
            ir_q          <= NOP_WORD;
            halted_q      <= 1'b0;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state         <= state_nxt;
            pc_q          <= pc_nxt;
            ir_q          <= ir_nxt;
            halted_q      <= halted_nxt;
            req_valid_q   <= req_valid_nxt;
            instr_valid_q <= instr_valid_nxt;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign instr          = ir_q;
    assign op             = ir_q[6:0];
    assign funct3         = ir_q[14:12];
    assign funct7         = ir_q[30];
    assign instr_valid    = instr_valid_q;
    assign halted         = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, sequential fetch, taken branch,
// backpressure/delayed response, misaligned halt, PC wrap and reset mid-fetch.
module tb_instr_fetch;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] pc;
    logic        instr_valid;
    logic        instr_done;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    instr_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr          (instr),
        .op             (op),
        .funct3         (funct3),
        .funct7         (funct7),
        .pc             (pc),
        .instr_valid    (instr_valid),
        .instr_done     (instr_done),
        .PCSrc          (PCSrc),
        .PCTarget       (PCTarget),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request, check its address, stall it for rdly cycles,
    // accept it, then deliver word after wdly cycles in WAIT.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] word,
                         input int rdly, input int wdly);
        for (int i = 0; i < 20; i++) begin
            if (imem_req_valid) break;
            step();
        end
        chk("req_valid", imem_req_valid, 1);
        chk("req_addr", imem_addr, addr);
        for (int k = 0; k < rdly; k++) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = JUNK;
            step();
            chk("req_held", imem_req_valid, 1);
            chk("addr_stable", imem_addr, addr);
        end
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = JUNK;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        chk("req_drop", imem_req_valid, 0);
        for (int k = 0; k < wdly; k++) begin
            instr_done = 1'b1;
            PCSrc      = 1'b1;
            PCTarget   = 32'h0000_0080;
            chk("wait_invalid", instr_valid, 0);
            step();
        end
        instr_done     = 1'b0;
        PCSrc          = 1'b0;
        PCTarget       = '0;
        chk("rsp_cycle_invalid", instr_valid, 0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        chk("instr_valid", instr_valid, 1);
        chk("instr", instr, word);
    endtask

    task automatic retire(input logic [31:0] pc_exp, input logic src, input logic [31:0] tgt);
        chk("issue_pc", pc, pc_exp);
        instr_done = 1'b1;
        PCSrc      = src;
        PCTarget   = tgt;
        step();
        instr_done = 1'b0;
        PCSrc      = 1'b0;
        PCTarget   = '0;
        chk("retire_invalid", instr_valid, 0);
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_done     = 1'b0;
        PCSrc          = 1'b0;
        PCTarget       = '0;

        // reset
        step();
        step();
        chk("rst_pc", pc, 32'h0);
        chk("rst_op", {25'd0, op}, 32'h13);
        chk("rst_instr", instr, NOP);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_halted", halted, 0);
        rst = 1'b0;
        imem_req_ready = 1'b1;   // ready with valid low must not count as acceptance
        step();
        imem_req_ready = 1'b0;
        chk("post_rst_req", imem_req_valid, 1);
        chk("post_rst_addr", imem_addr, 32'h0);

        // sequential fetch 0, 4, 8, 12
        fetch(32'h0, 32'h0050_0093, 0, 0);
        chk("seq_op", {25'd0, op}, 32'h13);
        retire(32'h0, 1'b0, 32'h0000_0100);
        fetch(32'h4, 32'h0010_0113, 0, 0);
        retire(32'h4, 1'b0, '0);
        fetch(32'h8, 32'h0020_0193, 0, 0);
        retire(32'h8, 1'b0, '0);
        fetch(32'hC, 32'h0000_006F, 0, 0);
        chk("jal_op", {25'd0, op}, 32'h6F);
        retire(32'hC, 1'b1, 32'h10);

        // taken branch at 0x10 to 0x40
        fetch(32'h10, 32'h0020_8663, 0, 0);
        chk("beq_op", {25'd0, op}, 32'h63);
        chk("beq_f3", {29'd0, funct3}, 32'h0);
        retire(32'h10, 1'b1, 32'h40);

        // backpressure and delayed response at 0x40
        fetch(32'h40, 32'h4020_8033, 5, 3);
        chk("sub_op", {25'd0, op}, 32'h33);
        chk("sub_f7", {31'd0, funct7}, 32'h1);
        chk("sub_f3", {29'd0, funct3}, 32'h0);

        // misaligned target halts
        retire(32'h40, 1'b1, 32'h42);
        chk("halt_flag", halted, 1);
        chk("halt_ir_nop", instr, NOP);
        chk("halt_pc", pc, 32'h40);
        for (int k = 0; k < 8; k++) begin
            imem_req_ready = 1'b1;
            imem_rsp_valid = 1'b1;
            instr_done     = 1'b1;
            PCSrc          = 1'b1;
            PCTarget       = 32'h100;
            step();
            chk("halt_no_req", imem_req_valid, 0);
            chk("halt_no_issue", instr_valid, 0);
        end
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        instr_done     = 1'b0;
        PCSrc          = 1'b0;
        PCTarget       = '0;
        chk("halt_sticky", halted, 1);

        // reset out of HALT, then PC wrap
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rehalt_clear", halted, 0);
        step();
        fetch(32'h0, 32'h0000_0013, 0, 1);
        retire(32'h0, 1'b1, 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 32'h0040_0213, 0, 0);
        retire(32'hFFFF_FFFC, 1'b0, '0);
        chk("wrap_pc", pc, 32'h0);

        // reset while in WAIT; response in the reset cycle and after it is dropped
        chk("wrap_req", imem_req_valid, 1);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        chk("wait_entered", imem_req_valid, 0);
        rst            = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        rst = 1'b0;
        chk("late_rst_ir", instr, NOP);
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        chk("late_rsp_ir", instr, NOP);
        chk("late_rsp_valid", instr_valid, 0);
        chk("late_req", imem_req_valid, 1);
        chk("late_addr", imem_addr, 32'h0);
        step();
        chk("late_still_fetch", imem_req_valid, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
